product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/multiplier_pkg.sv | 23 ++
 rtl/acc_block_counter.sv | 53 +++++
 rtl/product_accumulator.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// ----------------------------------------------------------------------------
// multiplier_pkg
// Shared definitions for the multiplier post-processing blocks.
//   - default widths / block length for product_accumulator
//   - block counter width (must hold the value 256)
//   - FSM state encoding used by product_accumulator
// ----------------------------------------------------------------------------
package multiplier_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_N_PROD = 4;

    // One bit wider than the external count so N_PROD = 256 is representable
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

endpackage : multiplier_pkg

// File: rtl/acc_block_counter.sv
// ----------------------------------------------------------------------------
// acc_block_counter
// Counts products accepted in the current block and flags the product that
// will complete the block.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   clr_i    : synchronous zero (abort or result handshake)
//   inc_i    : a product is accepted on this edge
//   count_o  : products accepted so far (low 8 bits)
//   last_o   : the next accepted product completes the block
// ----------------------------------------------------------------------------
module acc_block_counter
    import multiplier_pkg::*;
#(
    parameter int N_PROD = DEF_N_PROD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] count_o,
    output logic       last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: zero has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc_i) begin
            count_d = count_q + 9'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q[7:0];
    // Count is 0 in IDLE, so this also covers N_PROD == 1 on the first product
    assign last_o  = (count_q == CNT_W'(N_PROD - 1));

endmodule : acc_block_counter

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
// Sums blocks of N_PROD multiplier products and presents each block sum with
// a valid/ready handshake.
//   clk        : clock
//   reset      : asynchronous active-low reset
//   product    : product word from the multiplier
//   prod_valid : product qualifies this cycle
//   prod_ready : block can accept a product (not presenting a result)
//   clear      : synchronous abort; drops the partial sum and the flags
//   acc_out    : completed block sum (0 while acc_valid is low)
//   acc_valid  : block sum presented
//   acc_ready  : downstream takes acc_out
//   count      : products accepted in the current block
//   overflow   : sticky, a carry left the accumulator
//   dropped    : sticky, a product was offered while not ready
// ----------------------------------------------------------------------------
module product_accumulator
    import multiplier_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int N_PROD = DEF_N_PROD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] product,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [7:0]        count,
    output logic              overflow,
    output logic              dropped
);

    acc_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_out_q;
    logic             acc_valid_q;
    logic             prod_ready_q;
    logic             overflow_q;
    logic             dropped_q;

    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W:0]   add_s;
    logic             accept_s;
    logic             cnt_clr_s;
    logic             last_s;

    assign prod_ext_s = ACC_W'(product);
    // Extra top bit is the carry out of the accumulator
    assign add_s      = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(prod_ext_s);
    assign accept_s   = prod_valid & prod_ready_q & ~clear;
    assign cnt_clr_s  = clear | ((state_q == ST_HOLD) & acc_ready);

    acc_block_counter #(
        .N_PROD (N_PROD)
    ) u_counter (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (cnt_clr_s),
        .inc_i   (accept_s),
        .count_o (count),
        .last_o  (last_s)
    );

    // Block FSM with accumulator, presented result and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= {ACC_W{1'b0}};
            acc_out_q    <= {ACC_W{1'b0}};
            acc_valid_q  <= 1'b0;
            prod_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            acc_q        <= {ACC_W{1'b0}};
            acc_out_q    <= {ACC_W{1'b0}};
            acc_valid_q  <= 1'b0;
            prod_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_q <= prod_ext_s;
                        if (last_s) begin
                            state_q      <= ST_HOLD;
                            acc_out_q    <= prod_ext_s;
                            acc_valid_q  <= 1'b1;
                            prod_ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_q <= add_s[ACC_W-1:0];
                        if (add_s[ACC_W]) begin
                            overflow_q <= 1'b1;
                        end
                        if (last_s) begin
                            state_q      <= ST_HOLD;
                            acc_out_q    <= add_s[ACC_W-1:0];
                            acc_valid_q  <= 1'b1;
                            prod_ready_q <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    // Offers during HOLD are refused, even on the handshake edge
                    if (prod_valid) begin
                        dropped_q <= 1'b1;
                    end
                    if (acc_ready) begin
                        state_q      <= ST_IDLE;
                        acc_q        <= {ACC_W{1'b0}};
                        acc_out_q    <= {ACC_W{1'b0}};
                        acc_valid_q  <= 1'b0;
                        prod_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    acc_q        <= {ACC_W{1'b0}};
                    acc_out_q    <= {ACC_W{1'b0}};
                    acc_valid_q  <= 1'b0;
                    prod_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign acc_out    = acc_out_q;
    assign acc_valid  = acc_valid_q;
    assign prod_ready = prod_ready_q;
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;

endmodule : product_accumulator
